led_matrix_key_scanner: RTL

- Sequential scanner for an NxN switch/key matrix wired on the same row/column grid as the LED array.
- Strobes one column at a time, waits a settle interval, samples the row lines and debounces every key.
- Presents a debounced NxN key-state vector in the same flat layout the LED array driver consumes, so the game-of-life board can be edited by hand.
- Drives columns like the LED driver does; reads rows instead of driving them.

---
 rtl/led_matrix_key_scanner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/led_matrix_key_scanner.sv
// Column-strobed key matrix scanner with per-key debounce; keys uses the LED array's flat layout.
// Optional `KEY_SCANNER_LAST_KEY_EN adds last_idx/last_pressed reporting of the latest key change.
module led_matrix_key_scanner #(
  parameter int unsigned N        = 5,
  parameter int unsigned DWELL    = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [N-1:0]          rows_in,
  output logic [N-1:0]          cols,
  output logic [$clog2(N):0]    x,
  output logic [N*N-1:0]        keys,
  output logic                  key_event,
  output logic                  frame_done
`ifdef KEY_SCANNER_LAST_KEY_EN
  ,
  output logic [$clog2(N*N)-1:0] last_idx,
  output logic                   last_pressed
`endif
);

  localparam int unsigned XW = $clog2(N) + 1;
  localparam int unsigned DW = $clog2(DWELL);
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [N-1:0]   sync1_q, sync2_q;
  logic [N*N-1:0] keys_q, keys_d;
  logic [CW-1:0]  cnt_q [N*N];
  logic [CW-1:0]  cnt_d [N*N];
  logic           key_event_q, key_event_d;
  logic           frame_done_q, frame_done_d;
  logic [N*N-1:0] changed;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    dwell_d      = '0;
    keys_d       = keys_q;
    cnt_d        = cnt_q;
    key_event_d  = 1'b0;
    frame_done_d = 1'b0;
    changed      = '0;
    // Disable overrides everything, including a SAMPLE on the same edge.
    if (!ena) begin
      state_d = StIdle;
      x_d     = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StSettle;
          x_d     = '0;
        end
        StSettle: begin
          if (dwell_q == DW'(DWELL - 1)) state_d = StSample;
          else dwell_d = dwell_q + 1'b1;
        end
        StSample: begin
          for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
              if (c == int'(x_q)) begin
                if (sync2_q[r] == keys_q[r*N+c]) begin
                  cnt_d[r*N+c] = '0;
                end else if (cnt_q[r*N+c] == CW'(DEBOUNCE - 1)) begin
                  keys_d[r*N+c]  = sync2_q[r];
                  cnt_d[r*N+c]   = '0;
                  changed[r*N+c] = 1'b1;
                end else begin
                  cnt_d[r*N+c] = cnt_q[r*N+c] + 1'b1;
                end
              end
            end
          end
          key_event_d = |changed;
          if (x_q == XW'(N - 1)) begin
            x_d          = '0;
            frame_done_d = 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          state_d = StSettle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      dwell_q      <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      keys_q       <= '0;
      key_event_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < int'(N * N); i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      dwell_q      <= dwell_d;
      sync1_q      <= rows_in;
      sync2_q      <= sync1_q;
      keys_q       <= keys_d;
      key_event_q  <= key_event_d;
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    cols = '0;
    if (state_q != StIdle) cols = {{(N-1){1'b0}}, 1'b1} << x_q;
  end

  assign x          = x_q;
  assign keys       = keys_q;
  assign key_event  = key_event_q;
  assign frame_done = frame_done_q;

`ifdef KEY_SCANNER_LAST_KEY_EN
  localparam int unsigned IW = $clog2(N * N);

  logic [IW-1:0] last_idx_q, last_idx_d;
  logic          last_pressed_q, last_pressed_d;

  // Descending scan so the lowest changed index is the one left standing.
  always_comb begin
    last_idx_d     = last_idx_q;
    last_pressed_d = last_pressed_q;
    for (int i = int'(N * N) - 1; i >= 0; i--) begin
      if (changed[i]) begin
        last_idx_d     = IW'(i);
        last_pressed_d = keys_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_idx_q     <= '0;
      last_pressed_q <= 1'b0;
    end else begin
      last_idx_q     <= last_idx_d;
      last_pressed_q <= last_pressed_d;
    end
  end

  assign last_idx     = last_idx_q;
  assign last_pressed = last_pressed_q;
`endif

endmodule
